// File: rtl/fifo_drain.sv
// fifo_drain: read-side engine for the synchronous FIFO, with a 3-entry output buffer and credit-gated rd_en.
// Define FIFO_DRAIN_CNT_EN to build the xfer_cnt transfer counter; otherwise xfer_cnt is tied to zero.
module fifo_drain #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] dout,
  output logic                  rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  xfer_cnt
);

  logic [DATA_WIDTH-1:0] r_buf [3];
  logic [1:0]            r_wp;
  logic [1:0]            r_rp;
  logic [1:0]            r_occ;
  logic                  r_inflight;

  logic                  w_room;
  logic                  w_rd_en;
  logic                  w_pop;
  logic [1:0]            w_occ_nxt;
  logic [1:0]            w_wp_nxt;
  logic [1:0]            w_rp_nxt;

  // An in-flight read holds a buffer credit, so rd_en never needs m_ready.
  always_comb begin
    w_room    = ({1'b0, r_occ} + {2'b00, r_inflight}) < 3'd3;
    w_rd_en   = rst & en & ~empty & w_room;
    w_pop     = (r_occ != 2'd0) & m_ready;
    w_wp_nxt  = (r_wp == 2'd2) ? 2'd0 : r_wp + 2'd1;
    w_rp_nxt  = (r_rp == 2'd2) ? 2'd0 : r_rp + 2'd1;
    w_occ_nxt = r_occ;
    case ({r_inflight, w_pop})
      2'b10:   w_occ_nxt = r_occ + 2'd1;
      2'b01:   w_occ_nxt = r_occ - 2'd1;
      default: w_occ_nxt = r_occ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buf      <= '{default: '0};
      r_wp       <= '0;
      r_rp       <= '0;
      r_occ      <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
      if (r_inflight) begin
        r_buf[r_wp] <= dout;
        r_wp        <= w_wp_nxt;
      end
      if (w_pop) begin
        r_rp <= w_rp_nxt;
      end
      r_occ <= w_occ_nxt;
    end
  end

  assign rd_en   = w_rd_en;
  assign m_valid = (r_occ != 2'd0);
  assign m_data  = r_buf[r_rp];
  assign busy    = (r_occ != 2'd0) | r_inflight;

`ifdef FIFO_DRAIN_CNT_EN
  logic [CNT_WIDTH-1:0] r_xfer_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_xfer_cnt <= '0;
    end else if (w_pop) begin
      r_xfer_cnt <= r_xfer_cnt + 1'b1;
    end
  end

  assign xfer_cnt = r_xfer_cnt;
`else
  assign xfer_cnt = '0;
`endif

endmodule

// File: doc/fifo_drain.md
# fifo_drain

Read-side engine for the team's synchronous FIFO: watches the FIFO `empty` flag, issues `rd_en` pulses, captures `dout` one cycle later, and presents each word on a valid/ready stream to downstream logic. A 3-entry output buffer with read-credit accounting sustains one word per clock while absorbing downstream back-pressure, without a combinational path from `m_ready` to `rd_en`. Sits between the FIFO's read port and any consumer.

## Interface
- `DATA_WIDTH`, 8: width of FIFO `dout` and `m_data`.
- `CNT_WIDTH`, 16: width of the transfer counter `xfer_cnt`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  1 = allow new FIFO reads; 0 = stop issuing reads, still deliver buffered and in-flight words.
- `empty`  in  1  FIFO empty flag.
- `dout`  in  DATA_WIDTH  FIFO read data, valid the cycle after `rd_en`.
- `rd_en`  out  1  FIFO read strobe.
- `m_valid`  out  1  output word available.
- `m_ready`  in  1  downstream accepts the word when `m_valid` is also high.
- `m_data`  out  DATA_WIDTH  output word (head of buffer).
- `busy`  out  1  high while any word is buffered or in flight.
- `xfer_cnt`  out  CNT_WIDTH  count of words accepted downstream.

## Operation
- Internal state: 3-entry circular buffer (`wp`, `rp`, 2-bit each, wrap 2 to 0), occupancy `occ` (0..3), in-flight flag `inflight` (0/1).
- `rd_en = en & ~empty & (occ + inflight < 3)`. Computed from registered state and inputs only; never depends on `m_ready`.
- `inflight` register <= `rd_en`. When `inflight` is 1, `dout` is written to `buf[wp]` and `wp` advances.
- Pop: `m_valid & m_ready` advances `rp`. `occ` <= `occ + inflight - pop`. A write and a pop in the same cycle leave `occ` unchanged.
- `m_valid = (occ != 0)`. `m_data = buf[rp]`. Both hold stable while `m_valid & ~m_ready`.
- `busy = (occ != 0) | inflight`.
- `xfer_cnt` increments on each pop and wraps modulo 2^CNT_WIDTH.
- `en` deasserted mid-stream: no new `rd_en`. Any in-flight word is still captured, and all buffered words drain normally.
- `empty` high: no `rd_en`. The block never reads an empty FIFO.
- Buffer full (`occ` = 3, or `occ` = 2 with `inflight` = 1): `rd_en` stays low until a pop.
- Reset, async, active-low, at any time: `rd_en` = 0, `m_valid` = 0, `m_data` = 0, `busy` = 0, `xfer_cnt` = 0, `occ`, `wp`, `rp`, `inflight` = 0. A read in flight when reset asserts is discarded.

## Timing
- Read latency: `rd_en` high in cycle N. FIFO `dout` is valid in N+1 and captured at the end of N+1. `m_valid` rises in N+2 if the buffer was empty.
- Throughput: with `empty` = 0, `en` = 1 and `m_ready` = 1 held, `rd_en` is high every cycle from N and `m_valid` is high every cycle from N+2. Steady state is `occ` = 1, `inflight` = 1.
- Back-pressure: after `m_ready` drops, at most 3 words accumulate. `rd_en` stops no later than 1 cycle after the buffer reaches the full condition.
- Release of reset takes effect on the first rising `clk` edge with `rst` = 1.

## Configuration
- `FIFO_DRAIN_CNT_EN` defined: `xfer_cnt` counter is implemented as described.
- `FIFO_DRAIN_CNT_EN` undefined: counter logic is not compiled in. The `xfer_cnt` port remains and is tied to 0.
- All other behaviour is identical in both builds.

## Test plan
- Reset: hold `rst` = 0 with `empty` = 0 and `en` = 1 -> `rd_en` = 0, `m_valid` = 0, `busy` = 0, `xfer_cnt` = 0 throughout.
- Streaming: FIFO preloaded with 0x11..0x18, `en` = 1, `m_ready` = 1 -> `rd_en` high 8 consecutive cycles. `m_data` is 0x11..0x18 on 8 consecutive cycles starting 2 cycles after the first `rd_en`. `xfer_cnt` = 8 and `busy` = 0 afterwards.
- Back-pressure: 6 words queued, `m_ready` = 0 -> exactly 3 `rd_en` pulses, `m_valid` = 1 with `m_data` = first word held stable. Then `m_ready` = 1 -> remaining words delivered in order, with no loss or duplicate.
- Gating: `en` dropped 1 cycle after the first `rd_en` of a 4-word burst -> exactly 2 words delivered, then `rd_en` stays 0 and `busy` falls. Re-raising `en` delivers the remaining 2 words.
- Empty/underflow: FIFO emptied mid-stream -> no `rd_en` while `empty` = 1. Output stops after the last word, and `m_valid` is never high with stale data.
- Reset mid-operation: assert `rst` = 0 while `occ` = 2 and `inflight` = 1 -> all outputs return to reset values immediately. After release, no residual words appear on `m_data`.
